// File: rtl/bist_cut_engine.sv
// Self-contained BIST engine: pattern generator, truth-table CUT, serial signature, ones counter.
// Stuck-at fault injection on the CUT exists only when FAULT_INJECT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | applying one pattern per cycle, compacting the response
// DONE  | session finished, results held until the next start
module bist_cut_engine #(
    parameter int                  N_IN      = 4,
    parameter logic [2**N_IN-1:0]  TRUTH     = 16'h4816,
    parameter logic [N_IN-1:0]     LFSR_TAPS = 4'b1001,
    parameter int                  SIG_W     = 16,
    parameter logic [SIG_W-1:0]    SIG_POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]    GOLDEN    = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       fault_en,
    input  logic [$clog2(N_IN+1)-1:0]  fault_site,
    input  logic                       fault_val,
    output logic                       busy,
    output logic                       done,
    output logic [N_IN-1:0]            pattern,
    output logic                       cut_out,
    output logic [N_IN:0]              ones_cnt,
    output logic [SIG_W-1:0]           signature,
    output logic                       pass
);
    localparam int SITE_W = $clog2(N_IN+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic              modeLat;
    logic [N_IN-1:0]   patLeft;
    logic [N_IN-1:0]   cutIn;
    logic [N_IN-1:0]   patNext;
    logic [SIG_W-1:0]  sigNext;

`ifdef FAULT_INJECT_EN
    logic              faultEnLat;
    logic [SITE_W-1:0] faultSiteLat;
    logic              faultValLat;

    always_comb begin
        cutIn = pattern;
        for (int i = 0; i < N_IN; i++) begin
            if (faultEnLat && faultSiteLat == SITE_W'(i))
                cutIn[i] = faultValLat;
        end
        cut_out = TRUTH[cutIn];
        if (faultEnLat && faultSiteLat == SITE_W'(N_IN))
            cut_out = faultValLat;
    end
`else
    logic unusedFaultCfg;
    assign unusedFaultCfg = ^{fault_en, fault_site, fault_val};

    always_comb begin
        cutIn   = pattern;
        cut_out = TRUTH[cutIn];
    end
`endif

    always_comb begin
        sigNext = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                ^ {{(SIG_W-1){1'b0}}, cut_out};
        patNext = modeLat ? {pattern[N_IN-2:0], ^(pattern & LFSR_TAPS)}
                          : pattern + N_IN'(1);
    end

    // patLeft counts the patterns still to apply after the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pattern   <= '0;
            patLeft   <= '0;
            ones_cnt  <= '0;
            signature <= '0;
            pass      <= 1'b0;
            modeLat   <= 1'b0;
`ifdef FAULT_INJECT_EN
            faultEnLat   <= 1'b0;
            faultSiteLat <= '0;
            faultValLat  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        modeLat   <= mode;
`ifdef FAULT_INJECT_EN
                        faultEnLat   <= fault_en;
                        faultSiteLat <= fault_site;
                        faultValLat  <= fault_val;
`endif
                        ones_cnt  <= '0;
                        signature <= '0;
                        pass      <= 1'b0;
                        pattern   <= mode ? N_IN'(1) : '0;
                        patLeft   <= mode ? {{(N_IN-1){1'b1}}, 1'b0} : '1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    signature <= sigNext;
                    ones_cnt  <= ones_cnt + {{N_IN{1'b0}}, cut_out};
                    if (patLeft == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sigNext == GOLDEN);
                        state <= DONE;
                    end else begin
                        pattern <= patNext;
                        patLeft <= patLeft - N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
